// File: rtl/reg_file.sv
// rtl/reg_file.sv - one-write, two-read register file with 1-cycle registered reads and write forwarding
// Optional hardwired-zero r0; every output is a flop.
module reg_file #(
  parameter int WIDTH   = 8,
  parameter int NREGS   = 8,
  parameter int ZERO_R0 = 1,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             WE,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             RE_a,
  input  logic [AW-1:0]    raddr_a,
  output logic [WIDTH-1:0] rdata_a,
  input  logic             RE_b,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_b,
  output logic             wr_seen
);

  logic [WIDTH-1:0] regs [NREGS];
  logic             wr_ok;
  logic [WIDTH-1:0] next_a;
  logic [WIDTH-1:0] next_b;

  assign wr_ok = WE && !((ZERO_R0 != 0) && (waddr == '0));

  // A read of the register being written this edge returns the new data.
  always_comb begin
    next_a = (wr_ok && (raddr_a == waddr)) ? wdata : regs[raddr_a];
    next_b = (wr_ok && (raddr_b == waddr)) ? wdata : regs[raddr_b];
    if ((ZERO_R0 != 0) && (raddr_a == '0)) next_a = '0;
    if ((ZERO_R0 != 0) && (raddr_b == '0)) next_b = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      rdata_a <= '0;
      rdata_b <= '0;
      wr_seen <= 1'b0;
    end else begin
      if (wr_ok) regs[waddr] <= wdata;
      if (RE_a) rdata_a <= next_a;
      if (RE_b) rdata_b <= next_b;
      wr_seen <= wr_ok;
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - scoreboard bench for reg_file, ZERO_R0=1 and ZERO_R0=0 instances side by side
module tb_reg_file;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       we = 1'b0;
  logic [2:0] waddr = '0;
  logic [7:0] wdata = '0;
  logic       re_a = 1'b0;
  logic [2:0] raddr_a = '0;
  logic       re_b = 1'b0;
  logic [2:0] raddr_b = '0;
  logic [7:0] rdata_a0, rdata_b0, rdata_a1, rdata_b1;
  logic       wr_seen0, wr_seen1;

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    logic [7:0] a0, b0, a1, b1;
    logic       s0, s1;
  } exp_t;
  exp_t sb[$];

  // Reference state: index 0 models ZERO_R0=1, index 1 models ZERO_R0=0.
  logic [7:0] mem [2][8];
  logic [7:0] oa [2];
  logic [7:0] ob [2];
  logic       os [2];

  always #5 clk = ~clk;

  reg_file #(.WIDTH(8), .NREGS(8), .ZERO_R0(1)) dut0 (
    .clk(clk), .rst(rst), .WE(we), .waddr(waddr), .wdata(wdata),
    .RE_a(re_a), .raddr_a(raddr_a), .rdata_a(rdata_a0),
    .RE_b(re_b), .raddr_b(raddr_b), .rdata_b(rdata_b0), .wr_seen(wr_seen0)
  );

  reg_file #(.WIDTH(8), .NREGS(8), .ZERO_R0(0)) dut1 (
    .clk(clk), .rst(rst), .WE(we), .waddr(waddr), .wdata(wdata),
    .RE_a(re_a), .raddr_a(raddr_a), .rdata_a(rdata_a1),
    .RE_b(re_b), .raddr_b(raddr_b), .rdata_b(rdata_b1), .wr_seen(wr_seen1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, advance the model, queue the expected post-edge outputs.
  task automatic step(input logic r, input logic w, input logic [2:0] wa, input logic [7:0] wd,
                      input logic ra_en, input logic [2:0] ra, input logic rb_en, input logic [2:0] rb);
    exp_t e;
    @(negedge clk);
    rst = r; we = w; waddr = wa; wdata = wd;
    re_a = ra_en; raddr_a = ra; re_b = rb_en; raddr_b = rb;
    for (int d = 0; d < 2; d++) begin
      if (r) begin
        for (int k = 0; k < 8; k++) mem[d][k] = 8'h00;
        oa[d] = 8'h00; ob[d] = 8'h00; os[d] = 1'b0;
      end else begin
        // Write first, then read the updated array: gives forwarding for free,
        // and a hardwired r0 is simply never written.
        os[d] = w && !(d == 0 && wa == 3'd0);
        if (os[d]) mem[d][wa] = wd;
        if (ra_en) oa[d] = mem[d][ra];
        if (rb_en) ob[d] = mem[d][rb];
      end
    end
    e.a0 = oa[0]; e.b0 = ob[0]; e.s0 = os[0];
    e.a1 = oa[1]; e.b1 = ob[1]; e.s1 = os[1];
    sb.push_back(e);
  endtask

  task automatic after_edge;
    @(posedge clk);
    #2;
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("sb_rdata_a0", rdata_a0, e.a0);
      chk("sb_rdata_b0", rdata_b0, e.b0);
      chk("sb_wr_seen0", wr_seen0, e.s0);
      chk("sb_rdata_a1", rdata_a1, e.a1);
      chk("sb_rdata_b1", rdata_b1, e.b1);
      chk("sb_wr_seen1", wr_seen1, e.s1);
    end
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 8; k++) mem[d][k] = 8'h00;
      oa[d] = 8'h00; ob[d] = 8'h00; os[d] = 1'b0;
    end

    step(1, 0, 0, 8'h00, 0, 0, 0, 0);
    after_edge();
    chk("reset_rdata_a", rdata_a0, 8'h00);
    chk("reset_wr_seen", wr_seen0, 1'b0);

    // Reset wipes a prior write
    step(0, 1, 3, 8'hA5, 0, 0, 0, 0);
    step(1, 1, 3, 8'h5A, 1, 3, 0, 0);
    step(0, 0, 0, 8'h00, 1, 3, 0, 0);
    after_edge();
    chk("rst_clears_r3", rdata_a0, 8'h00);
    chk("rst_wr_seen", wr_seen0, 1'b0);

    // Write then read, wr_seen pulse
    step(0, 1, 5, 8'h3C, 0, 0, 0, 0);
    after_edge();
    chk("wr_seen_pulse", wr_seen0, 1'b1);
    step(0, 0, 0, 8'h00, 1, 5, 0, 0);
    after_edge();
    chk("read_r5", rdata_a0, 8'h3C);
    chk("wr_seen_drop", wr_seen0, 1'b0);

    // Forwarding on both ports
    step(0, 1, 2, 8'h11, 0, 0, 0, 0);
    step(0, 1, 2, 8'h77, 1, 2, 1, 2);
    after_edge();
    chk("fwd_a", rdata_a0, 8'h77);
    chk("fwd_b", rdata_b0, 8'h77);

    // Zero register behaviour
    step(0, 1, 0, 8'hFF, 0, 0, 0, 0);
    after_edge();
    chk("r0_wr_seen_zr1", wr_seen0, 1'b0);
    chk("r0_wr_seen_zr0", wr_seen1, 1'b1);
    step(0, 1, 0, 8'hEE, 1, 0, 1, 0);
    after_edge();
    chk("r0_fwd_zr1", rdata_a0, 8'h00);
    chk("r0_fwd_zr0", rdata_b1, 8'hEE);
    step(0, 0, 0, 8'h00, 1, 0, 0, 0);
    after_edge();
    chk("r0_read_zr1", rdata_a0, 8'h00);
    chk("r0_read_zr0", rdata_a1, 8'hEE);

    // Hold when read enable is low
    step(0, 1, 4, 8'h42, 0, 0, 0, 0);
    step(0, 0, 0, 8'h00, 0, 0, 1, 4);
    after_edge();
    chk("hold_load", rdata_b0, 8'h42);
    step(0, 1, 4, 8'h99, 0, 0, 0, 4);
    after_edge();
    chk("hold_during_write", rdata_b0, 8'h42);
    step(0, 0, 0, 8'h00, 0, 0, 0, 4);
    after_edge();
    chk("hold_idle", rdata_b0, 8'h42);
    step(0, 0, 0, 8'h00, 0, 0, 1, 4);
    after_edge();
    chk("hold_reload", rdata_b0, 8'h99);

    // Random soak
    void'($urandom(32'h1234_5678));
    for (int i = 0; i < 1000; i++) begin
      step(($urandom_range(63) == 0), 1'($urandom), 3'($urandom), 8'($urandom),
           1'($urandom), 3'($urandom), 1'($urandom), 3'($urandom));
    end

    repeat (3) @(posedge clk);
    #2;
    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
